// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg: opcodes, FSM states and access-size helpers for the memory stage. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam logic [5:0] c_op_lb  = 6'h20;
    localparam logic [5:0] c_op_lh  = 6'h21;
    localparam logic [5:0] c_op_lw  = 6'h23;
    localparam logic [5:0] c_op_lbu = 6'h24;
    localparam logic [5:0] c_op_lhu = 6'h25;
    localparam logic [5:0] c_op_sb  = 6'h28;
    localparam logic [5:0] c_op_sh  = 6'h29;
    localparam logic [5:0] c_op_sw  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Unknown opcodes fall back to a full-word access.
    function automatic acc_size_t op_size(input logic [5:0] op);
        case (op)
            c_op_lb, c_op_lbu, c_op_sb: op_size = SZ_BYTE;
            c_op_lh, c_op_lhu, c_op_sh: op_size = SZ_HALF;
            default:                    op_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        op_signed = (op == c_op_lb) || (op == c_op_lh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_lane_align: big-endian store lane/byte-enable generation and load      |
// | extraction with sign/zero extension. Purely combinational.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    acc_size_t   w_size;
    logic        w_sign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_size = op_size(opcode);
        w_sign = op_signed(opcode);
        be     = 4'b1111;
        wdata  = store_data;

        // Sub-word stores replicate across lanes; enables pick the target lane.
        case (w_size)
            SZ_BYTE: begin
                wdata = {4{store_data[7:0]}};
                if (write) be = 4'b1000 >> addr_lo;
            end
            SZ_HALF: begin
                wdata = {2{store_data[15:0]}};
                if (write) be = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase

        case (addr_lo)
            2'd0:    w_byte = rdata[31:24];
            2'd1:    w_byte = rdata[23:16];
            2'd2:    w_byte = rdata[15:8];
            default: w_byte = rdata[7:0];
        endcase
        w_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];

        case (w_size)
            SZ_BYTE: load_data = {{24{w_sign & w_byte[7]}}, w_byte};
            SZ_HALF: load_data = {{16{w_sign & w_half[15]}}, w_half};
            default: load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage: dual-slot memory stage serializing two accesses over req/ack.   |
// | Optional MEM_PERF_CNT_EN adds the mem_stall_cycles counter output.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_stage
    import mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] aluResult1_PR,
    input  logic [31:0] aluResult2_PR,
    input  logic [31:0] readDataB1_PR,
    input  logic [31:0] readDataB2_PR,
    input  logic [31:0] Instr1_PR,
    input  logic [31:0] Instr2_PR,
    input  logic        MemRead1_PR,
    input  logic        MemRead2_PR,
    input  logic        MemWrite1_PR,
    input  logic        MemWrite2_PR,
    input  logic        MemtoReg1_PR,
    input  logic        MemtoReg2_PR,
    input  logic        do_writeback1_PR,
    input  logic        do_writeback2_PR,
    input  logic [4:0]  writeRegister1_PR,
    input  logic [4:0]  writeRegister2_PR,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        MEM_stall,
    output logic [31:0] Data1_MEM,
    output logic [31:0] Data2_MEM,
    output logic [4:0]  writeRegister1_MEM,
    output logic [4:0]  writeRegister2_MEM,
    output logic        do_writeback1_MEM,
    output logic        do_writeback2_MEM,
    output logic [31:0] Data1_WB,
    output logic [31:0] Data2_WB,
    output logic [4:0]  writeRegister1_WB,
    output logic [4:0]  writeRegister2_WB,
    output logic        do_writeback1_WB,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0] mem_stall_cycles,
`endif
    output logic        do_writeback2_WB
);

    mem_state_t  r_state;
    mem_state_t  w_next;
    logic        r_req;
    logic [31:0] r_load1;
    logic [31:0] r_load2;

    logic        w_op1;
    logic        w_op2;
    logic        w_ack;
    logic        w_sel2;
    logic [5:0]  w_opcode;
    logic [31:0] w_addr;
    logic [31:0] w_sdata;
    logic        w_write;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic        w_unused;

    assign w_op1    = MemRead1_PR | MemWrite1_PR;
    assign w_op2    = MemRead2_PR | MemWrite2_PR;
    assign w_ack    = dmem_ack & r_req;
    assign w_unused = ^{Instr1_PR[25:0], Instr2_PR[25:0]};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == ACC1) || (w_next == ACC2);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_op1)      w_next = ACC1;
                else if (w_op2) w_next = ACC2;
            end
            ACC1: if (w_ack) w_next = w_op2 ? ACC2 : DONE;
            ACC2: if (w_ack) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The held execute register keeps the active slot's fields stable until ack.
    assign w_sel2   = (r_state == ACC2);
    assign w_opcode = w_sel2 ? Instr2_PR[31:26] : Instr1_PR[31:26];
    assign w_addr   = w_sel2 ? aluResult2_PR    : aluResult1_PR;
    assign w_sdata  = w_sel2 ? readDataB2_PR    : readDataB1_PR;
    assign w_write  = w_sel2 ? MemWrite2_PR     : MemWrite1_PR;

    mem_lane_align u_lane_align (
        .opcode     (w_opcode),
        .write      (w_write),
        .addr_lo    (w_addr[1:0]),
        .store_data (w_sdata),
        .rdata      (dmem_rdata),
        .be         (w_be),
        .wdata      (w_wdata),
        .load_data  (w_load)
    );

    assign dmem_req   = r_req;
    assign dmem_we    = r_req & w_write;
    assign dmem_addr  = r_req ? {w_addr[31:2], 2'b00} : 32'd0;
    assign dmem_be    = r_req ? w_be : 4'd0;
    assign dmem_wdata = dmem_we ? w_wdata : 32'd0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_load1 <= 32'd0;
            r_load2 <= 32'd0;
        end else begin
            if (w_ack && (r_state == ACC1)) r_load1 <= w_load;
            if (w_ack && (r_state == ACC2)) r_load2 <= w_load;
        end
    end

    assign MEM_stall = ((r_state == IDLE) && (w_op1 || w_op2)) ||
                       (r_state == ACC1) || (r_state == ACC2);

    assign Data1_MEM          = MemtoReg1_PR ? r_load1 : aluResult1_PR;
    assign Data2_MEM          = MemtoReg2_PR ? r_load2 : aluResult2_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    assign writeRegister2_MEM = writeRegister2_PR;
    assign do_writeback1_MEM  = do_writeback1_PR & ~MEM_stall;
    assign do_writeback2_MEM  = do_writeback2_PR & ~MEM_stall;

    // While stalled the WB register injects a bubble but keeps its payload.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Data1_WB          <= 32'd0;
            Data2_WB          <= 32'd0;
            writeRegister1_WB <= 5'd0;
            writeRegister2_WB <= 5'd0;
            do_writeback1_WB  <= 1'b0;
            do_writeback2_WB  <= 1'b0;
        end else if (!MEM_stall) begin
            Data1_WB          <= Data1_MEM;
            Data2_WB          <= Data2_MEM;
            writeRegister1_WB <= writeRegister1_PR;
            writeRegister2_WB <= writeRegister2_PR;
            do_writeback1_WB  <= do_writeback1_PR;
            do_writeback2_WB  <= do_writeback2_PR;
        end else begin
            do_writeback1_WB  <= 1'b0;
            do_writeback2_WB  <= 1'b0;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)         r_stall_cnt <= 32'd0;
        else if (MEM_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign mem_stall_cycles = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage: scoreboard bench for mem_stage with a behavioural memory.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] bdata;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        wb;
        logic [4:0]  rdst;
    } slot_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [31:0] d1;
        logic [4:0]  r1;
        logic        w1;
        logic [31:0] d2;
        logic [4:0]  r2;
        logic        w2;
    } wb_t;

    logic        CLK, RESET;
    logic [31:0] aluResult1_PR, aluResult2_PR, readDataB1_PR, readDataB2_PR;
    logic [31:0] Instr1_PR, Instr2_PR;
    logic        MemRead1_PR, MemRead2_PR, MemWrite1_PR, MemWrite2_PR;
    logic        MemtoReg1_PR, MemtoReg2_PR, do_writeback1_PR, do_writeback2_PR;
    logic [4:0]  writeRegister1_PR, writeRegister2_PR;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        MEM_stall;
    logic [31:0] Data1_MEM, Data2_MEM, Data1_WB, Data2_WB;
    logic [4:0]  writeRegister1_MEM, writeRegister2_MEM, writeRegister1_WB, writeRegister2_WB;
    logic        do_writeback1_MEM, do_writeback2_MEM, do_writeback1_WB, do_writeback2_WB;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] mem_stall_cycles;
`endif

    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 0;
    int          exp_stall_total = 0;
    logic [31:0] mem [0:1023];
    acc_t        acc_q[$];
    wb_t         wb_q[$];

    mem_stage dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .aluResult1_PR      (aluResult1_PR),
        .aluResult2_PR      (aluResult2_PR),
        .readDataB1_PR      (readDataB1_PR),
        .readDataB2_PR      (readDataB2_PR),
        .Instr1_PR          (Instr1_PR),
        .Instr2_PR          (Instr2_PR),
        .MemRead1_PR        (MemRead1_PR),
        .MemRead2_PR        (MemRead2_PR),
        .MemWrite1_PR       (MemWrite1_PR),
        .MemWrite2_PR       (MemWrite2_PR),
        .MemtoReg1_PR       (MemtoReg1_PR),
        .MemtoReg2_PR       (MemtoReg2_PR),
        .do_writeback1_PR   (do_writeback1_PR),
        .do_writeback2_PR   (do_writeback2_PR),
        .writeRegister1_PR  (writeRegister1_PR),
        .writeRegister2_PR  (writeRegister2_PR),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .MEM_stall          (MEM_stall),
        .Data1_MEM          (Data1_MEM),
        .Data2_MEM          (Data2_MEM),
        .writeRegister1_MEM (writeRegister1_MEM),
        .writeRegister2_MEM (writeRegister2_MEM),
        .do_writeback1_MEM  (do_writeback1_MEM),
        .do_writeback2_MEM  (do_writeback2_MEM),
        .Data1_WB           (Data1_WB),
        .Data2_WB           (Data2_WB),
        .writeRegister1_WB  (writeRegister1_WB),
        .writeRegister2_WB  (writeRegister2_WB),
        .do_writeback1_WB   (do_writeback1_WB),
`ifdef MEM_PERF_CNT_EN
        .mem_stall_cycles   (mem_stall_cycles),
`endif
        .do_writeback2_WB   (do_writeback2_WB)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t mk(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] bdata,
                                 input logic rd, input logic wr, input logic m2r, input logic wb,
                                 input logic [4:0] rdst);
        slot_t s;
        s.op = op; s.alu = alu; s.bdata = bdata; s.rd = rd; s.wr = wr;
        s.m2r = m2r; s.wb = wb; s.rdst = rdst;
        return s;
    endfunction

    task automatic exp_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata);
        acc_t a;
        a.we = we; a.addr = addr; a.be = be; a.wdata = wdata;
        acc_q.push_back(a);
    endtask

    task automatic exp_wb(input logic [31:0] d1, input logic [4:0] r1, input logic w1,
                          input logic [31:0] d2, input logic [4:0] r2, input logic w2);
        wb_t e;
        e.d1 = d1; e.r1 = r1; e.w1 = w1; e.d2 = d2; e.r2 = r2; e.w2 = w2;
        wb_q.push_back(e);
    endtask

    task automatic drive(input slot_t s1, input slot_t s2);
        aluResult1_PR = s1.alu;  readDataB1_PR = s1.bdata; Instr1_PR = {s1.op, 26'h0ABCDE};
        MemRead1_PR = s1.rd; MemWrite1_PR = s1.wr; MemtoReg1_PR = s1.m2r;
        do_writeback1_PR = s1.wb; writeRegister1_PR = s1.rdst;
        aluResult2_PR = s2.alu;  readDataB2_PR = s2.bdata; Instr2_PR = {s2.op, 26'h0ABCDE};
        MemRead2_PR = s2.rd; MemWrite2_PR = s2.wr; MemtoReg2_PR = s2.m2r;
        do_writeback2_PR = s2.wb; writeRegister2_PR = s2.rdst;
    endtask

    // Drive one bundle, watch the stall window, then compare the WB register.
    task automatic run_bundle(input slot_t s1, input slot_t s2, input int delay, input int exp_stall);
        int  n;
        wb_t e;
        @(negedge CLK);
        drive(s1, s2);
        ack_delay = delay;
        exp_stall_total += exp_stall;
        #1;
        n = 0;
        while (MEM_stall && n < 200) begin
            if (n == 0) begin
                check("req_in_idle", {31'd0, dmem_req}, 32'd0);
            end else begin
                check("req_in_acc", {31'd0, dmem_req}, 32'd1);
                check("wb_bubble", {30'd0, do_writeback1_WB, do_writeback2_WB}, 32'd0);
            end
            check("fwd_wb_stalled", {30'd0, do_writeback1_MEM, do_writeback2_MEM}, 32'd0);
            n++;
            @(negedge CLK);
            #1;
        end
        check("stall_cycles", n, exp_stall);
        check("fwd_wb_released", {30'd0, do_writeback1_MEM, do_writeback2_MEM}, {30'd0, s1.wb, s2.wb});
        @(posedge CLK);
        #1;
        check("wb_pending", wb_q.size(), 32'd1);
        if (wb_q.size() != 0) begin
            e = wb_q.pop_front();
            check("data1_wb", Data1_WB, e.d1);
            check("wr1_wb", {27'd0, writeRegister1_WB}, {27'd0, e.r1});
            check("dowb1_wb", {31'd0, do_writeback1_WB}, {31'd0, e.w1});
            check("data2_wb", Data2_WB, e.d2);
            check("wr2_wb", {27'd0, writeRegister2_WB}, {27'd0, e.r2});
            check("dowb2_wb", {31'd0, do_writeback2_WB}, {31'd0, e.w2});
        end
    endtask

    // Memory responder: acks after ack_delay waiting cycles, scoreboards each access.
    initial begin
        int          cnt;
        logic [31:0] first_addr;
        logic [31:0] w;
        acc_t        a;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        cnt        = 0;
        first_addr = 32'd0;
        forever begin
            @(negedge CLK);
            dmem_ack = 1'b0;
            if (dmem_req && RESET) begin
                if (cnt == 0) first_addr = dmem_addr;
                else check("addr_stable", dmem_addr, first_addr);
                if (cnt >= ack_delay) begin
                    check("acc_expected", {31'd0, acc_q.size() != 0}, 32'd1);
                    if (acc_q.size() != 0) begin
                        a = acc_q.pop_front();
                        check("acc_we", {31'd0, dmem_we}, {31'd0, a.we});
                        check("acc_addr", dmem_addr, a.addr);
                        check("acc_be", {28'd0, dmem_be}, {28'd0, a.be});
                        if (a.we) check("acc_wdata", dmem_wdata, a.wdata);
                    end
                    w = mem[dmem_addr[11:2]];
                    if (dmem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_be[b]) w[b*8 +: 8] = dmem_wdata[b*8 +: 8];
                        mem[dmem_addr[11:2]] = w;
                    end
                    dmem_rdata = w;
                    dmem_ack   = 1'b1;
                    cnt        = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        slot_t nop;
        int    n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        nop = mk(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Reset: captured load visible through MemtoReg must read back zero.
        RESET = 1'b0;
        drive(mk(OP_NOP, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0), nop);
        repeat (3) @(negedge CLK);
        #1;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_stall", {31'd0, MEM_stall}, 32'd0);
        check("rst_load1", Data1_MEM, 32'd0);
        check("rst_wb", {Data1_WB ^ Data2_WB, 32'd0} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        check("rst_wb_ctl", {20'd0, writeRegister1_WB, writeRegister2_WB, do_writeback1_WB, do_writeback2_WB}, 32'd0);
`ifdef MEM_PERF_CNT_EN
        check("rst_perf", mem_stall_cycles, 32'd0);
`endif
        @(negedge CLK);
        drive(nop, nop);
        RESET = 1'b1;

        // SW with a non-memory partner: two stall cycles.
        exp_access(1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF);
        exp_wb(32'h100, 5'd0, 1'b0, 32'h55, 5'd5, 1'b1);
        run_bundle(mk(OP_SW, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0),
                   mk(OP_NOP, 32'h55, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5), 0, 2);

        // SB then LBU to the same byte; the load observes the store.
        mem[32'h100 >> 2] = 32'd0;
        exp_access(1'b1, 32'h100, 4'b0100, 32'h1212_1212);
        exp_access(1'b0, 32'h100, 4'b1111, 32'd0);
        exp_wb(32'h101, 5'd0, 1'b0, 32'h0000_0012, 5'd7, 1'b1);
        run_bundle(mk(OP_SB, 32'h101, 32'h0000_0012, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0),
                   mk(OP_LBU, 32'h101, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7), 0, 3);

        // LB sign extension and LHU zero extension.
        mem[32'h100 >> 2] = 32'h0000_00F0;
        mem[32'h200 >> 2] = 32'h0000_F00F;
        exp_access(1'b0, 32'h100, 4'b1111, 32'd0);
        exp_access(1'b0, 32'h200, 4'b1111, 32'd0);
        exp_wb(32'hFFFF_FFF0, 5'd3, 1'b1, 32'h0000_F00F, 5'd4, 1'b1);
        run_bundle(mk(OP_LB, 32'h103, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3),
                   mk(OP_LHU, 32'h202, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4), 0, 3);

        // Five wait cycles per access: 1 + 6 + 6 stall cycles.
        mem[32'h300 >> 2] = 32'hCAFE_F00D;
        exp_access(1'b0, 32'h300, 4'b1111, 32'd0);
        exp_access(1'b1, 32'h300, 4'b0011, 32'hBEEF_BEEF);
        exp_wb(32'hCAFE_F00D, 5'd9, 1'b1, 32'h302, 5'd0, 1'b0);
        run_bundle(mk(OP_LW, 32'h300, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9),
                   mk(OP_SH, 32'h302, 32'h1234_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 5, 13);

        // Two SWs to one address; slot 1 has MemRead and MemWrite set (a write).
        exp_access(1'b1, 32'h400, 4'b1111, 32'h1111_1111);
        exp_access(1'b1, 32'h400, 4'b1111, 32'h2222_2222);
        exp_wb(32'h400, 5'd0, 1'b0, 32'h400, 5'd0, 1'b0);
        run_bundle(mk(OP_SW, 32'h400, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0),
                   mk(OP_SW, 32'h400, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 1, 5);

        // Slot 2 value is final; then SH into the low half.
        exp_access(1'b0, 32'h400, 4'b1111, 32'd0);
        exp_access(1'b1, 32'h400, 4'b0011, 32'h8001_8001);
        exp_wb(32'h2222_2222, 5'd10, 1'b1, 32'h402, 5'd0, 1'b0);
        run_bundle(mk(OP_LW, 32'h400, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10),
                   mk(OP_SH, 32'h402, 32'h0000_8001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 0, 3);

        exp_access(1'b0, 32'h400, 4'b1111, 32'd0);
        exp_wb(32'hFFFF_8001, 5'd11, 1'b1, 32'h77, 5'd12, 1'b1);
        run_bundle(mk(OP_LH, 32'h402, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11),
                   mk(OP_NOP, 32'h77, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12), 0, 2);

        // Only slot 2 has an op: IDLE goes straight to ACC2.
        exp_access(1'b0, 32'h400, 4'b1111, 32'd0);
        exp_wb(32'h88, 5'd13, 1'b1, 32'h0000_0022, 5'd14, 1'b1);
        run_bundle(mk(OP_NOP, 32'h88, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13),
                   mk(OP_LB, 32'h400, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14), 0, 2);

        // Back-to-back non-memory bundles.
        for (int i = 0; i < 6; i++) begin
            slot_t a, b;
            a = mk(OP_NOP, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)));
            b = mk(OP_NOP, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)));
            exp_wb(a.alu, a.rdst, a.wb, b.alu, b.rdst, b.wb);
            run_bundle(a, b, 0, 0);
        end

        // Reset while ACC2 waits on a slow ack.
        @(negedge CLK);
        drive(nop, mk(OP_LW, 32'h500, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd20));
        ack_delay = 50;
        exp_access(1'b0, 32'h500, 4'b1111, 32'd0);
        #1;
        n = 0;
        while (!dmem_req && n < 10) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("acc2_req_before_rst", {31'd0, dmem_req}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("midrst_req", {31'd0, dmem_req}, 32'd0);
        check("midrst_we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
        check("midrst_addr", dmem_addr, 32'd0);
        check("midrst_data1_wb", Data1_WB, 32'd0);
        check("midrst_data2_wb", Data2_WB, 32'd0);
        check("midrst_wb_ctl", {20'd0, writeRegister1_WB, writeRegister2_WB, do_writeback1_WB, do_writeback2_WB}, 32'd0);
`ifdef MEM_PERF_CNT_EN
        check("midrst_perf", mem_stall_cycles, 32'd0);
`endif
        acc_q.delete();
        exp_stall_total = 0;
        @(negedge CLK);
        drive(nop, nop);
        RESET = 1'b1;

        // Back in IDLE: a plain bundle passes in one cycle, then a load works.
        exp_wb(32'h99, 5'd1, 1'b1, 32'hAA, 5'd2, 1'b1);
        run_bundle(mk(OP_NOP, 32'h99, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1),
                   mk(OP_NOP, 32'hAA, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2), 0, 0);
        exp_access(1'b0, 32'h100, 4'b1111, 32'd0);
        exp_wb(32'h0000_00F0, 5'd15, 1'b1, 32'd0, 5'd0, 1'b0);
        run_bundle(mk(OP_LW, 32'h100, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15), nop, 0, 2);
`ifdef MEM_PERF_CNT_EN
        check("perf_total", mem_stall_cycles, exp_stall_total);
`endif
        check("acc_all_consumed", acc_q.size(), 32'd0);

        @(negedge CLK);
        drive(nop, nop);
        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
